// File: rtl/washing_machine_pkg.sv
// Shared types and defaults for the washing-machine sequencer.
// The WM_WATCHDOG_EN build option is interpreted in washing_machine_ctrl.
package washing_machine_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StDetergent,
    StWash,
    StDrain,
    StSpin,
    StDone,
    StFault
  } wm_state_e;

  localparam int unsigned DefWashTicks  = 16;
  localparam int unsigned DefRinseTicks = 8;
  localparam int unsigned DefSpinTicks  = 12;
  localparam int unsigned DefNumRinse   = 1;
  localparam int unsigned DefWdogTicks  = 64;
  localparam int unsigned PassW         = 4;

  function automatic int unsigned max_ticks(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/wm_tick_timer.sv
// Shared duration timer: synchronous clear, count enable, terminal flag at limit-1.
module wm_tick_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [Width-1:0] i_limit,
  output logic             o_terminal
);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + Width'(1);
    end
  end

  assign o_terminal = (r_count == (i_limit - Width'(1)));

endmodule

// File: rtl/washing_machine_ctrl.sv
// Washing-machine sequencer: Moore FSM with rinse passes, abort path and one shared timer.
// Define WM_WATCHDOG_EN to add the fill/drain watchdog and the FAULT state.
module washing_machine_ctrl
  import washing_machine_pkg::*;
#(
  parameter int unsigned WASH_TICKS  = DefWashTicks,
  parameter int unsigned RINSE_TICKS = DefRinseTicks,
  parameter int unsigned SPIN_TICKS  = DefSpinTicks,
  parameter int unsigned NUM_RINSE   = DefNumRinse,
  parameter int unsigned WDOG_TICKS  = DefWdogTicks
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             door_close,
  input  logic             start,
  input  logic             filled,
  input  logic             detergent_added,
  input  logic             drained,
  input  logic             abort,
  output logic             door_lock,
  output logic             motor_on,
  output logic             fill_valve_on,
  output logic             drain_valve_on,
  output logic             soap_wash,
  output logic             water_wash,
  output logic             done,
  output logic             fault,
  output logic [PassW-1:0] pass_idx
);

  localparam int unsigned TimerW =
      $clog2(max_ticks(WASH_TICKS, RINSE_TICKS, SPIN_TICKS, WDOG_TICKS) + 1);

  wm_state_e         r_state, w_state_next;
  logic [PassW-1:0]  r_pass, w_pass_next;
  logic              r_abort, w_abort_next;
  logic [TimerW-1:0] w_limit;
  logic              w_tmr_en;
  logic              w_tick_done;
  logic              w_last_pass;

  assign w_last_pass = (r_pass == PassW'(NUM_RINSE));

  always_comb begin
    w_limit = TimerW'(SPIN_TICKS);
    case (r_state)
      StWash:         w_limit = (r_pass == '0) ? TimerW'(WASH_TICKS) : TimerW'(RINSE_TICKS);
      StFill, StDrain: w_limit = TimerW'(WDOG_TICKS);
      default:        ;
    endcase
  end

`ifdef WM_WATCHDOG_EN
  assign w_tmr_en = (r_state == StWash) || (r_state == StSpin) ||
                    (r_state == StFill) || (r_state == StDrain);
`else
  assign w_tmr_en = (r_state == StWash) || (r_state == StSpin);
`endif

  // Any state change restarts the timer, so each timed phase starts from zero.
  wm_tick_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_state_next != r_state),
    .i_enable   (w_tmr_en),
    .i_limit    (w_limit),
    .o_terminal (w_tick_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_pass  <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pass  <= w_pass_next;
      r_abort <= w_abort_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pass_next  = r_pass;
    w_abort_next = r_abort;
    case (r_state)
      StIdle: begin
        w_abort_next = 1'b0;
        if (start && door_close) begin
          w_state_next = StFill;
          w_pass_next  = '0;
        end
      end
      StFill: begin
        if (abort) begin
          w_state_next = StDrain;
          w_abort_next = 1'b1;
        end else if (filled) begin
          w_state_next = (r_pass == '0) ? StDetergent : StWash;
`ifdef WM_WATCHDOG_EN
        end else if (w_tick_done) begin
          w_state_next = StFault;
`endif
        end
      end
      StDetergent: begin
        if (abort) begin
          w_state_next = StDrain;
          w_abort_next = 1'b1;
        end else if (detergent_added) begin
          w_state_next = StWash;
        end
      end
      StWash: begin
        if (abort) begin
          w_state_next = StDrain;
          w_abort_next = 1'b1;
        end else if (w_tick_done) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        // An aborted cycle skips the spin once the drum is empty.
        if (abort) begin
          w_state_next = StDone;
        end else if (drained) begin
          w_state_next = r_abort ? StDone : StSpin;
`ifdef WM_WATCHDOG_EN
        end else if (w_tick_done) begin
          w_state_next = StFault;
`endif
        end
      end
      StSpin: begin
        if (abort) begin
          w_state_next = StDone;
        end else if (w_tick_done) begin
          if (w_last_pass) begin
            w_state_next = StDone;
          end else begin
            w_state_next = StFill;
            w_pass_next  = r_pass + PassW'(1);
          end
        end
      end
      StDone: begin
        if (!door_close) w_state_next = StIdle;
      end
      StFault: ;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    door_lock      = 1'b0;
    motor_on       = 1'b0;
    fill_valve_on  = 1'b0;
    drain_valve_on = 1'b0;
    soap_wash      = 1'b0;
    water_wash     = 1'b0;
    done           = 1'b0;
    fault          = 1'b0;
    case (r_state)
      StIdle: ;
      StFill: begin
        door_lock     = 1'b1;
        fill_valve_on = 1'b1;
      end
      StDetergent: door_lock = 1'b1;
      StWash: begin
        door_lock  = 1'b1;
        motor_on   = 1'b1;
        soap_wash  = (r_pass == '0);
        water_wash = (r_pass != '0);
      end
      StDrain: begin
        door_lock      = 1'b1;
        drain_valve_on = 1'b1;
      end
      StSpin: begin
        door_lock      = 1'b1;
        motor_on       = 1'b1;
        drain_valve_on = 1'b1;
      end
      StDone: done = 1'b1;
      StFault: begin
        door_lock = 1'b1;
`ifdef WM_WATCHDOG_EN
        fault     = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign pass_idx = r_pass;

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// Bench for washing_machine_ctrl: two instances (two rinses / no rinse), phase-level reference.
// With WM_WATCHDOG_EN defined it also exercises the fill watchdog and FAULT state.
module tb_washing_machine_ctrl;

  localparam int unsigned WashT  = 8;
  localparam int unsigned RinseT = 4;
  localparam int unsigned SpinT  = 6;
  localparam int unsigned WdogT  = 16;

  localparam int P_IDLE  = 0;
  localparam int P_FILL  = 1;
  localparam int P_DET   = 2;
  localparam int P_WASH  = 3;
  localparam int P_DRAIN = 4;
  localparam int P_SPIN  = 5;
  localparam int P_DONE  = 6;
  localparam int P_FAULT = 7;

  logic clk = 1'b0;
  logic reset0, reset1;
  logic door_close, start, filled, detergent_added, drained, abort;
  wire  [7:0] o0, o1;
  wire  [3:0] pass0, pass1;

  int checks = 0;
  int errors = 0;
  int dsel   = 0;

  always #5 clk = ~clk;

  washing_machine_ctrl #(
    .WASH_TICKS (WashT), .RINSE_TICKS (RinseT), .SPIN_TICKS (SpinT),
    .NUM_RINSE (2), .WDOG_TICKS (WdogT)
  ) u_dut0 (
    .clk (clk), .reset (reset0), .door_close (door_close), .start (start),
    .filled (filled), .detergent_added (detergent_added), .drained (drained), .abort (abort),
    .door_lock (o0[7]), .motor_on (o0[6]), .fill_valve_on (o0[5]), .drain_valve_on (o0[4]),
    .soap_wash (o0[3]), .water_wash (o0[2]), .done (o0[1]), .fault (o0[0]),
    .pass_idx (pass0)
  );

  washing_machine_ctrl #(
    .WASH_TICKS (WashT), .RINSE_TICKS (RinseT), .SPIN_TICKS (SpinT),
    .NUM_RINSE (0), .WDOG_TICKS (WdogT)
  ) u_dut1 (
    .clk (clk), .reset (reset1), .door_close (door_close), .start (start),
    .filled (filled), .detergent_added (detergent_added), .drained (drained), .abort (abort),
    .door_lock (o1[7]), .motor_on (o1[6]), .fill_valve_on (o1[5]), .drain_valve_on (o1[4]),
    .soap_wash (o1[3]), .water_wash (o1[2]), .done (o1[1]), .fault (o1[0]),
    .pass_idx (pass1)
  );

  // Actuator table per phase: {lock, motor, fill, drain, soap, water, done, fault}.
  function automatic logic [7:0] exp_vec(input int ph, input int p);
    case (ph)
      P_FILL:  return 8'b1010_0000;
      P_DET:   return 8'b1000_0000;
      P_WASH:  return (p == 0) ? 8'b1100_1000 : 8'b1100_0100;
      P_DRAIN: return 8'b1001_0000;
      P_SPIN:  return 8'b1101_0000;
      P_DONE:  return 8'b0000_0010;
      P_FAULT: return 8'b1000_0001;
      default: return 8'b0000_0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // p < 0 means the pass index is not defined for this point of the sequence.
  task automatic chk_state(input int ph, input int p, input string tag);
    logic [7:0] o;
    logic [3:0] pi;
    o  = (dsel != 0) ? o1 : o0;
    pi = (dsel != 0) ? pass1 : pass0;
    chk({tag, "_outs"}, 32'(o), 32'(exp_vec(ph, p)));
    if (p >= 0) chk({tag, "_pass"}, 32'(pi), 32'(p));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Randomise every input that the given phase must ignore.
  task automatic drive(input int ph);
    start = 1'($urandom_range(0, 1));
    abort = (ph == P_IDLE || ph == P_DONE || ph == P_FAULT) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (ph != P_IDLE && ph != P_DONE) door_close = 1'($urandom_range(0, 1));
    filled          = (ph == P_FILL)  ? 1'b0 : 1'($urandom_range(0, 1));
    detergent_added = (ph == P_DET)   ? 1'b0 : 1'($urandom_range(0, 1));
    drained         = (ph == P_DRAIN) ? 1'b0 : 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_reset();
    if (dsel != 0) reset1 = 1'b1;
    else reset0 = 1'b1;
    step();
    reset0 = (dsel != 0) ? reset0 : 1'b0;
    reset1 = (dsel != 0) ? 1'b0 : reset1;
  endtask

  // Stay n cycles in phase ph; the last cycle raises the phase's sensor, if it has one.
  task automatic phase(input int ph, input int p, input int n, input int ab_pass,
                       input int ab_ph, input int ab_cyc, output bit ab);
    ab = 1'b0;
    for (int c = 1; c <= n; c++) begin
      chk_state(ph, p, $sformatf("ph%0d_p%0d_c%0d", ph, p, c));
      drive(ph);
      if (c == n) begin
        if (ph == P_FILL) filled = 1'b1;
        if (ph == P_DET) detergent_added = 1'b1;
        if (ph == P_DRAIN) drained = 1'b1;
      end
      if (p == ab_pass && ph == ab_ph && c == ab_cyc) begin
        abort = 1'b1;
        ab    = 1'b1;
      end
      step();
      if (ab) break;
    end
    abort = 1'b0;
  endtask

  task automatic run_program(input int ab_pass, input int ab_ph, input int ab_cyc,
                             input int rst_pass);
    bit ab;
    int hit_ph, hit_pass, nr, fp, n;
    hit_ph   = -1;
    hit_pass = 0;
    nr       = (dsel != 0) ? 0 : 2;
    drive(P_IDLE);
    start      = 1'b1;
    door_close = 1'b1;
    step();
    for (int p = 0; p <= nr; p++) begin
      hit_pass = p;
      phase(P_FILL, p, $urandom_range(1, 4), ab_pass, ab_ph, ab_cyc, ab);
      if (ab) begin hit_ph = P_FILL; break; end
      if (p == 0) begin
        phase(P_DET, p, $urandom_range(1, 4), ab_pass, ab_ph, ab_cyc, ab);
        if (ab) begin hit_ph = P_DET; break; end
      end
      phase(P_WASH, p, (p == 0) ? WashT : RinseT, ab_pass, ab_ph, ab_cyc, ab);
      if (ab) begin hit_ph = P_WASH; break; end
      phase(P_DRAIN, p, $urandom_range(1, 4), ab_pass, ab_ph, ab_cyc, ab);
      if (ab) begin hit_ph = P_DRAIN; break; end
      if (p == rst_pass) begin
        chk_state(P_SPIN, p, "pre_rst_spin1");
        drive(P_SPIN);
        step();
        chk_state(P_SPIN, p, "pre_rst_spin2");
        drive(P_SPIN);
        pulse_reset();
        chk_state(P_IDLE, 0, "after_reset");
        return;
      end
      phase(P_SPIN, p, SpinT, ab_pass, ab_ph, ab_cyc, ab);
      if (ab) begin hit_ph = P_SPIN; break; end
    end
    if (hit_ph == P_FILL || hit_ph == P_DET || hit_ph == P_WASH)
      phase(P_DRAIN, hit_pass, $urandom_range(1, 4), -1, -1, 0, ab);
    fp = (hit_ph >= 0) ? hit_pass : nr;
    n  = $urandom_range(1, 3);
    for (int c = 1; c <= n; c++) begin
      chk_state(P_DONE, fp, "done");
      drive(P_DONE);
      door_close = (c != n);
      step();
    end
    chk_state(P_IDLE, -1, "idle_after_done");
  endtask

  initial begin
    int ab_pass, ab_ph, ab_cyc;
    door_close = 1'b0; start = 1'b0; filled = 1'b0;
    detergent_added = 1'b0; drained = 1'b0; abort = 1'b0;
    reset0 = 1'b1;
    reset1 = 1'b1;
    repeat (2) @(posedge clk);
    step();
    dsel = 1;
    chk_state(P_IDLE, 0, "reset_dut1");
    dsel = 0;
    chk_state(P_IDLE, 0, "reset_dut0");
    reset0 = 1'b0;

    // Start held with the door open must not leave IDLE.
    start      = 1'b1;
    door_close = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_state(P_IDLE, 0, "door_open");
    end
    run_program(-1, -1, 0, -1);
    run_program(0, P_WASH, 3, -1);
    run_program(-1, -1, 0, 1);
    run_program(-1, -1, 0, -1);
    run_program(1, P_SPIN, 6, -1);
    run_program(0, P_DET, 1, -1);
    for (int i = 0; i < 8; i++) begin
      ab_pass = $urandom_range(0, 2);
      ab_ph   = $urandom_range(0, 5);
      ab_cyc  = $urandom_range(1, 6);
      run_program(ab_pass, (ab_ph == 0) ? -1 : ab_ph, ab_cyc, -1);
    end

    // Single-pass instance.
    reset0 = 1'b1;
    reset1 = 1'b0;
    dsel   = 1;
    step();
    chk_state(P_IDLE, 0, "dut1_idle");
    run_program(-1, -1, 0, -1);
    run_program(0, P_SPIN, 2, -1);
    run_program(0, P_DRAIN, 1, -1);

`ifdef WM_WATCHDOG_EN
    reset1 = 1'b1;
    reset0 = 1'b0;
    dsel   = 0;
    step();
    drive(P_IDLE);
    start      = 1'b1;
    door_close = 1'b1;
    step();
    for (int c = 1; c <= int'(WdogT); c++) begin
      chk_state(P_FILL, 0, "wdog_fill");
      drive(P_FILL);
      step();
    end
    for (int c = 0; c < 4; c++) begin
      chk_state(P_FAULT, 0, "fault_hold");
      drive(P_FAULT);
      abort = 1'b1;
      step();
    end
    abort = 1'b0;
    pulse_reset();
    chk_state(P_IDLE, 0, "fault_reset");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/washing_machine_ctrl.md
# washing_machine_ctrl

Parametrised washing-machine sequencer: replaces externally supplied wash/spin timeouts with internal tick counters, adds a configurable number of rinse passes and an abort path, and drives the same valve/motor/lock actuators. Sits between the front-panel/sensor inputs and the actuator drivers. Sequential Moore FSM plus one shared duration timer.

## Interface
- WASH_TICKS, 16: soap-wash duration in clk cycles (≥1)
- RINSE_TICKS, 8: water-rinse duration per pass (≥1)
- SPIN_TICKS, 12: spin duration per pass (≥1)
- NUM_RINSE, 1: rinse passes after the soap pass (0..15)
- WDOG_TICKS, 64: fill/drain watchdog limit (used only with WM_WATCHDOG_EN)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- door_close  in  1  door closed sensor
- start  in  1  start request, level-sampled
- filled  in  1  drum-full sensor
- detergent_added  in  1  detergent confirmation
- drained  in  1  drum-empty sensor
- abort  in  1  user abort request
- door_lock  out  1  door solenoid locked
- motor_on  out  1  drum motor enable
- fill_valve_on  out  1  inlet valve
- drain_valve_on  out  1  drain pump/valve
- soap_wash  out  1  soap pass active (WASH state, pass 0)
- water_wash  out  1  rinse pass active (WASH state, pass ≥1)
- done  out  1  cycle complete
- fault  out  1  watchdog fault
- pass_idx  out  4  current pass (0 = soap, 1..NUM_RINSE = rinse)

## Operation
- States: IDLE, FILL, DETERGENT, WASH, DRAIN, SPIN, DONE, FAULT.
- IDLE→FILL when start && door_close on the same sampled edge; pass_idx←0. Otherwise stay.
- FILL: fill_valve_on; →DETERGENT on filled if pass_idx==0, else →WASH.
- DETERGENT: all actuators off except lock; →WASH on detergent_added.
- WASH: motor_on; soap_wash/water_wash per pass_idx; lasts exactly WASH_TICKS (pass 0) or RINSE_TICKS cycles, then →DRAIN.
- DRAIN: drain_valve_on; →SPIN on drained.
- SPIN: motor_on and drain_valve_on for SPIN_TICKS cycles; then if pass_idx==NUM_RINSE →DONE, else pass_idx+1, →FILL.
- DONE: done=1, door_lock=0; →IDLE when door_close==0.
- door_lock=1 in every state except IDLE and DONE.
- abort in FILL, DETERGENT or WASH →DRAIN with internal abort flag set; after drained →DONE (SPIN skipped). abort in DRAIN/SPIN: SPIN terminates, →DONE. abort ignored in IDLE/DONE/FAULT.
- start ignored outside IDLE. door_close deassertion outside IDLE/DONE ignored (door is locked).
- Simultaneous abort and sensor/timer completion: abort wins.
- Timer: cleared on every state entry, increments while in WASH/SPIN (and FILL/DRAIN with watchdog); terminal when count == ticks−1. Width $clog2(max(WASH_TICKS,RINSE_TICKS,SPIN_TICKS,WDOG_TICKS)+1).

## Timing
- Outputs decoded combinationally from the state register only; valid the cycle the state is entered. No input-to-output combinational path.
- Any state transition occurs on the first clk edge where its condition is high: 1-cycle latency sensor→actuator change.
- WASH high for exactly WASH_TICKS/RINSE_TICKS cycles; SPIN exactly SPIN_TICKS cycles (unless aborted).
- Reset (any time, including mid-cycle): state IDLE, timer 0, pass_idx 0, abort flag 0; all outputs 0 the cycle after the reset edge.

## Configuration
- WM_WATCHDOG_EN defined: timer runs in FILL and DRAIN; reaching WDOG_TICKS cycles without filled/drained →FAULT. FAULT: door_lock=1, fault=1, all valves/motor off; exit only via reset. abort ignored in FAULT.
- Undefined: FILL/DRAIN wait indefinitely; FAULT state unreachable; fault tied 0.

## Structure
- washing_machine_pkg: state enum (3-bit), default tick constants, pass_idx width constant.
- One sub-module wm_tick_timer: clear, enable, terminal-count compare against a run-time limit input; instantiated once, limit muxed by state/pass.

## Test plan
- WASH_TICKS=8, RINSE_TICKS=4, SPIN_TICKS=6, NUM_RINSE=2, sensors pulsed promptly → soap_wash high 8 cycles, water_wash high 4 cycles twice, 3 SPIN phases of 6 cycles, done=1, pass_idx=2.
- NUM_RINSE=0 → single soap pass, one SPIN, DONE; water_wash never asserted.
- abort asserted on 3rd WASH cycle of pass 0 → DRAIN next cycle, drained → DONE, no SPIN, motor_on 0 from the abort edge+1.
- start=1, door_close=0 for 10 cycles → stays IDLE, all outputs 0; then door_close=1 → FILL next edge.
- reset pulsed during SPIN of pass 1 → all outputs 0, pass_idx 0 next cycle; fresh start runs full sequence.
- With WM_WATCHDOG_EN, WDOG_TICKS=16, filled never asserted → FAULT after 16 FILL cycles, fault=1, door_lock=1, fill_valve_on=0; only reset clears.
